// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared types and constants for the RV32M multiplier sequencer.
package multiplier_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CTRL_W = 3;

    localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } seq_state_e;

    typedef struct packed {
        logic signed_A;
        logic signed_B;
        logic upper;
    } mult_ctrl_t;

endpackage

// File: rtl/multiplier_seq_decode.sv
// multiplier_seq_decode: RV32M funct3 to multiplier operand-sign / upper-half control.
module multiplier_seq_decode
    import multiplier_pkg::*;
(
    input  logic [F3_W-1:0]   funct3_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    mult_ctrl_t ctrl;

    always_comb begin
        ctrl      = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_MUL:    ctrl = '{signed_A: 1'b1, signed_B: 1'b1, upper: 1'b0};
            F3_MULH:   ctrl = '{signed_A: 1'b1, signed_B: 1'b1, upper: 1'b1};
            F3_MULHSU: ctrl = '{signed_A: 1'b1, signed_B: 1'b0, upper: 1'b1};
            F3_MULHU:  ctrl = '{signed_A: 1'b0, signed_B: 1'b0, upper: 1'b1};
            default:   illegal_o = 1'b1;
        endcase
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: issue/response controller between RV32M execute and the iterative multiplier.
// Define MULT_SEQ_CACHE_EN to add a one-entry {A, B, funct3} -> result cache.
module multiplier_sequencer
    import multiplier_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [F3_W-1:0] req_funct3_i,
    input  logic [XLEN-1:0] req_op_A_i,
    input  logic [XLEN-1:0] req_op_B_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_result_o,
    output logic [RD_W-1:0] rsp_rd_o,
    output logic            rsp_error_o,
    output logic            mult_en_o,
    output logic [XLEN-1:0] mult_op_A_o,
    output logic [XLEN-1:0] mult_op_B_o,
    output logic            mult_signed_A_o,
    output logic            mult_signed_B_o,
    output logic            mult_upper_o,
    input  logic [XLEN-1:0] mult_result_i,
    input  logic            mult_done_i
);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    mult_ctrl_t        ctrl_q, ctrl_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d, valid_q, valid_d, en_q, en_d;

    logic [CTRL_W-1:0] dec_bits;
    mult_ctrl_t        dec_ctrl;
    logic              dec_illegal;
    logic              accept, timeout, wait_done, wait_tmo, drain_tmo;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_res;

    multiplier_seq_decode u_decode (
        .funct3_i  (req_funct3_i),
        .ctrl_o    (dec_bits),
        .illegal_o (dec_illegal)
    );

    assign dec_ctrl    = mult_ctrl_t'(dec_bits);
    // A flush in IDLE blocks the handshake in that same cycle.
    assign req_ready_o = ready_q & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout     = (cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
    assign wait_done   = (state_q == ST_WAIT) & ~flush_i & mult_done_i;
    assign wait_tmo    = (state_q == ST_WAIT) & ~flush_i & ~mult_done_i & timeout;
    assign drain_tmo   = (state_q == ST_DRAIN) & ~mult_done_i & timeout;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks done/timeout/response handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (dec_illegal || cache_hit) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end else if (mult_done_i || timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mult_done_i || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
        en_d    = (state_d == ST_ISSUE);
        cnt_d   = ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) ? cnt_inc : '0;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        err_d   = err_q;
        if (accept) begin
            op_a_d = req_op_A_i;
            op_b_d = req_op_B_i;
            rd_d   = req_rd_i;
            ctrl_d = dec_ctrl;
            if (dec_illegal) begin
                res_d = '0;
                err_d = 1'b1;
            end else if (cache_hit) begin
                res_d = cache_res;
                err_d = 1'b0;
            end
        end
        if (wait_done) begin
            res_d = mult_result_i;
            err_d = 1'b0;
        end else if (wait_tmo) begin
            res_d = '0;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

`ifdef MULT_SEQ_CACHE_EN
    logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d, cache_res_q, cache_res_d;
    logic [F3_W-1:0] cache_f3_q, cache_f3_d, f3_q, f3_d;
    logic            cache_vld_q, cache_vld_d;

    assign cache_hit = cache_vld_q & ~dec_illegal & (req_op_A_i == cache_a_q)
                     & (req_op_B_i == cache_b_q) & (req_funct3_i == cache_f3_q);
    assign cache_res = cache_res_q;

    // Fill on clean completion; any flush or lost done drops the entry
    always_comb begin
        f3_d        = accept ? req_funct3_i : f3_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_f3_d  = cache_f3_q;
        cache_res_d = cache_res_q;
        cache_vld_d = cache_vld_q;
        if (wait_done) begin
            cache_a_d   = op_a_q;
            cache_b_d   = op_b_q;
            cache_f3_d  = f3_q;
            cache_res_d = mult_result_i;
            cache_vld_d = 1'b1;
        end
        if (flush_i || wait_tmo || drain_tmo) begin
            cache_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            f3_q        <= '0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_f3_q  <= '0;
            cache_res_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            f3_q        <= f3_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_f3_q  <= cache_f3_d;
            cache_res_q <= cache_res_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    assign rsp_valid_o     = valid_q;
    assign rsp_result_o    = res_q;
    assign rsp_rd_o        = rd_q;
    assign rsp_error_o     = err_q;
    assign mult_en_o       = en_q;
    assign mult_op_A_o     = op_a_q;
    assign mult_op_B_o     = op_b_q;
    assign mult_signed_A_o = ctrl_q.signed_A;
    assign mult_signed_B_o = ctrl_q.signed_B;
    assign mult_upper_o    = ctrl_q.upper;

endmodule
